eep_i2c_target: RTL

//  I2C target (responder) emulating a small EEPROM-style register file: the far end of the

---
 rtl/eep_i2c_target.sv | 301 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/eep_i2c_target.sv
// eep_i2c_target: I2C target emulating a small EEPROM-style register file.
// Answers DEV_ADDR and supports byte writes with an auto-incrementing pointer,
// random reads and current-address reads. The pointer wraps modulo 2**MEM_AW.
// Optional build macro I2C_TGT_GLITCH_FILTER_EN adds a 3-sample majority filter
// on the synchronized SCL/SDA, which rejects single-clk glitches.
module eep_i2c_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned MEM_AW   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              busy,
  output logic              wr_strobe,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR_S,
    DEV_ACK,
    WORD_ADDR,
    WA_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic              sda_oe_d, busy_d, wr_strobe_d;
  logic [MEM_AW-1:0] wr_addr_d;
  logic [7:0]        wr_data_d;
  logic              mem_we;
  logic [7:0]        mem [MEM_DEPTH];

  logic [1:0] scl_sync, sda_sync;
  logic       scl_f, sda_f;
  logic       scl_q, sda_q;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_c;
  logic [7:0] rd_byte;
  logic       last_bit;

  // Two-flop synchronizers for the asynchronous pad inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
    end
  end

`ifdef I2C_TGT_GLITCH_FILTER_EN
  logic [2:0] scl_hist, sda_hist;

  // Three-sample history feeding the majority vote
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_hist <= 3'b111;
      sda_hist <= 3'b111;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
    end
  end

  // Majority of three: a one-clk pulse never wins the vote
  always_comb begin
    scl_f = (scl_hist[0] & scl_hist[1]) | (scl_hist[0] & scl_hist[2]) |
            (scl_hist[1] & scl_hist[2]);
    sda_f = (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) |
            (sda_hist[1] & sda_hist[2]);
  end
`else
  // Unfiltered: synchronized values go straight to edge detection
  always_comb begin
    scl_f = scl_sync[1];
    sda_f = sda_sync[1];
  end
`endif

  // Previous filtered values for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
    end
  end

  // Bus events; START/STOP are SDA edges while SCL stays high
  always_comb begin
    scl_rise  = scl_f & ~scl_q;
    scl_fall  = ~scl_f & scl_q;
    start_det = scl_f & scl_q & sda_q & ~sda_f;
    stop_det  = scl_f & scl_q & ~sda_q & sda_f;
    byte_c    = {shift_q, sda_f};
    last_bit  = (bit_cnt_q == CNT_W'(7));
    rd_byte   = mem[ptr_q];
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sda_oe    <= sda_oe_d;
      busy      <= busy_d;
      wr_strobe <= wr_strobe_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
    end
  end

  // Register file; written in the same cycle the host strobe is raised
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[ptr_q] <= byte_c;
    end
  end

  // Next-state and output logic; START/STOP override bit handling
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe;
    busy_d      = busy;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr;
    wr_data_d   = wr_data;
    mem_we      = 1'b0;

    if (start_det) begin
      state_d   = DEV_ADDR_S;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end

        DEV_ADDR_S: begin
          if (scl_rise) begin
            shift_d   = byte_c[6:0];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (last_bit) begin
              bit_cnt_d = '0;
              if (byte_c[7:1] == DEV_ADDR) begin
                state_d = DEV_ACK;
                busy_d  = 1'b1;
                rw_d    = byte_c[0];
              end else begin
                state_d = WAIT_STOP;
                busy_d  = 1'b0;
              end
            end
          end
        end

        // First fall after bit 8 pulls SDA; the fall after bit 9 releases it
        DEV_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_d = 1'b1;
            end else if (rw_q) begin
              sda_oe_d  = ~rd_byte[7];
              state_d   = RD_DATA;
              bit_cnt_d = '0;
            end else begin
              sda_oe_d  = 1'b0;
              state_d   = WORD_ADDR;
              bit_cnt_d = '0;
            end
          end
        end

        WORD_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_c[6:0];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (last_bit) begin
              ptr_d     = byte_c[MEM_AW-1:0];
              bit_cnt_d = '0;
              state_d   = WA_ACK;
            end
          end
        end

        WA_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              state_d   = WR_DATA;
              bit_cnt_d = '0;
            end
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            shift_d   = byte_c[6:0];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (last_bit) begin
              mem_we      = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = ptr_q;
              wr_data_d   = byte_c;
              ptr_d       = ptr_q + MEM_AW'(1);
              bit_cnt_d   = '0;
              state_d     = WR_ACK;
            end
          end
        end

        // Drive each bit after the SCL fall; release after the eighth bit
        RD_DATA: begin
          if (scl_rise) begin
            if (bit_cnt_q != CNT_W'(8)) begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end else if (scl_fall) begin
            if (bit_cnt_q == CNT_W'(8)) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK;
            end else begin
              sda_oe_d = ~rd_byte[3'(3'd7 - bit_cnt_q[2:0])];
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_f) begin
              ptr_d     = ptr_q + MEM_AW'(1);
              bit_cnt_d = '0;
              state_d   = RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
              state_d  = WAIT_STOP;
            end
          end
        end

        WAIT_STOP: begin
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

endmodule
